// File: rtl/parking_pkg.sv
// parking_pkg: shared FSM states, slot constants and slot-to-one-hot helper.
package parking_pkg;

    typedef enum logic [1:0] {IDLE, ON, OFF} state_t;

    localparam int SLOT_NONE = 0;

    // Slots are 1-based; slot 0 means no LED at all.
    function automatic logic [15:0] slot_onehot(input logic [3:0] s);
        return (s == 4'(SLOT_NONE)) ? 16'd0 : 16'd1 << (s - 4'd1);
    endfunction

endpackage

// File: rtl/led_phase_timer.sv
// led_phase_timer: loadable down-counter; expire is high in the last cycle of a loaded phase.
module led_phase_timer #(
    parameter int W = 3
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         load,
    input  logic [W-1:0] load_val,
    output logic         expire
);

    logic [W-1:0] cnt;

    always_ff @(posedge clk)
        if (!rst_n)
            cnt <= '0;
        else if (load)
            cnt <= load_val;
        else if (cnt != '0)
            cnt <= cnt - 1'b1;

    assign expire = (cnt == W'(1));

endmodule

// File: rtl/led_slot_indicator.sv
// led_slot_indicator: blinks the LED of an assigned parking slot for a set number of periods.
// Define LED_OCCUPANCY_EN to add the occupied port and overlay steady occupancy on the LEDs.
module led_slot_indicator
    import parking_pkg::*;
#(
    parameter  int N_SLOTS    = 6,
    parameter  int ON_CYCLES  = 4,
    parameter  int OFF_CYCLES = 4,
    parameter  int BLINKS     = 3,
    localparam int SLOT_W     = $clog2(N_SLOTS + 1)
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic [SLOT_W-1:0]  slot,
    input  logic               cancel,
`ifdef LED_OCCUPANCY_EN
    input  logic [N_SLOTS-1:0] occupied,
`endif
    output logic [N_SLOTS-1:0] led,
    output logic               busy,
    output logic               done,
    output logic               err
);

    localparam int BW   = (BLINKS == 0) ? 1 : $clog2(BLINKS + 1);
    localparam int MAXC = (ON_CYCLES > OFF_CYCLES) ? ON_CYCLES : OFF_CYCLES;
    localparam int TW   = $clog2(MAXC + 1);

    state_t             state, state_n;
    logic [SLOT_W-1:0]  slot_q, slot_n;
    logic [BW-1:0]      bc, bc_n;
    logic               load, expire, valid, done_n, err_n;
    logic [TW-1:0]      load_val;
    logic [N_SLOTS-1:0] mask_n, led_n;

    led_phase_timer #(.W(TW)) u_timer (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (load),
        .load_val (load_val),
        .expire   (expire)
    );

    assign valid = start && slot != '0 && slot <= SLOT_W'(N_SLOTS);

    always_comb begin
        state_n  = state;
        slot_n   = slot_q;
        bc_n     = bc;
        load     = 1'b0;
        load_val = TW'(ON_CYCLES);
        done_n   = 1'b0;
        err_n    = start && !valid && !cancel;
        if (cancel) begin
            state_n = IDLE;
            slot_n  = SLOT_W'(SLOT_NONE);
            bc_n    = '0;
        end else if (valid) begin
            state_n = ON;
            slot_n  = slot;
            bc_n    = '0;
            load    = 1'b1;
        end else begin
            case (state)
                ON: if (expire) begin
                    state_n  = OFF;
                    load     = 1'b1;
                    load_val = TW'(OFF_CYCLES);
                end
                OFF: if (expire) begin
                    // BLINKS=0 never reaches the final-blink branch.
                    if (BLINKS != 0 && bc == BW'(BLINKS - 1)) begin
                        state_n = IDLE;
                        slot_n  = SLOT_W'(SLOT_NONE);
                        done_n  = 1'b1;
                    end else begin
                        state_n = ON;
                        bc_n    = bc + 1'b1;
                        load    = 1'b1;
                    end
                end
                default: ;
            endcase
        end
        mask_n = N_SLOTS'(slot_onehot(4'(slot_n)));
`ifdef LED_OCCUPANCY_EN
        led_n  = ((state_n == ON) ? mask_n : '0) | (occupied & ~mask_n);
`else
        led_n  = (state_n == ON) ? mask_n : '0;
`endif
    end

    always_ff @(posedge clk)
        if (!rst_n) begin
            state  <= IDLE;
            slot_q <= SLOT_W'(SLOT_NONE);
            bc     <= '0;
            led    <= '0;
            busy   <= 1'b0;
            done   <= 1'b0;
            err    <= 1'b0;
        end else begin
            state  <= state_n;
            slot_q <= slot_n;
            bc     <= bc_n;
            led    <= led_n;
            busy   <= state_n != IDLE;
            done   <= done_n;
            err    <= err_n;
        end

endmodule

// File: doc/led_slot_indicator.md
# led_slot_indicator

Parametrised parking-slot LED indicator for the guidance panel. On a start request it latches the assigned slot number and blinks that slot's LED for a programmable number of on/off periods, then signals completion. It is the generalised successor of the fixed 6-slot indicator, adding:
- configurable slot count and blink timing;
- finite or continuous blinking;
- cancel, retrigger and invalid-slot flagging.

## Interface
- N_SLOTS, 6, number of parking slots/LEDs (1..15)
- ON_CYCLES, 4, clock cycles LED is lit per blink (>=1)
- OFF_CYCLES, 4, clock cycles LED is dark per blink (>=1)
- BLINKS, 3, on/off periods per request; 0 = blink until cancel
- SLOT_W, derived $clog2(N_SLOTS+1), slot number width (local)

Ports:
- clk  in  1  system clock
- rst_n  in  1  reset; synchronous, active-low
- start  in  1  request pulse; samples slot
- slot  in  SLOT_W  assigned slot, 1..N_SLOTS; 0 = none
- cancel  in  1  abort current indication
- occupied  in  N_SLOTS  steady occupancy map (only with LED_OCCUPANCY_EN)
- led  out  N_SLOTS  LED drive, bit k = slot k+1
- busy  out  1  indication in progress
- done  out  1  one-cycle pulse on normal completion
- err  out  1  one-cycle pulse on rejected start

## Operation
- FSM states:
  - IDLE -> ON on valid start.
  - ON -> OFF after ON_CYCLES.
  - OFF -> ON if blinks remain or BLINKS=0.
  - OFF -> IDLE after final OFF phase; pulse done.
- Valid start: 1 <= slot <= N_SLOTS.
  - Latch slot.
  - Clear the phase timer and blink counter.
- Invalid start (slot 0 or > N_SLOTS):
  - Pulse err.
  - State unchanged, including an ongoing indication.
- Retrigger: a valid start while busy restarts from ON with the new slot. The old slot's LED goes dark immediately; no done is generated for the old indication.
- cancel: in any state -> IDLE with led cleared. No done pulse.
  - Priority: rst_n > cancel > start.
- In ON, led is one-hot at bit slot-1. In IDLE/OFF the blink contribution is 0.
- Blink counter width: $clog2(BLINKS+1). It is not used when BLINKS=0.

## Timing
- All outputs registered.
- Reset values: led=0, busy=0, done=0, err=0, state IDLE, latched slot 0.
- Reset mid-indication takes effect at the next clock edge. No done pulse is produced.
- Start sampled at edge t:
  - led and busy reflect the request from cycle t+1.
  - err is high in cycle t+1 only.
- ON phase lasts exactly ON_CYCLES cycles. OFF phase lasts exactly OFF_CYCLES cycles.
- Finite run: busy is high for BLINKS*(ON_CYCLES+OFF_CYCLES) cycles. done is high in the first cycle after that, with busy=0.
- A start on the same edge as the final OFF->IDLE transition is a retrigger: no done, new indication begins.
- cancel sampled at edge t gives led=0 and busy=0 from cycle t+1.

## Configuration
- LED_OCCUPANCY_EN defined:
  - occupied port exists.
  - led = blink vector | (occupied & ~assigned-slot mask), registered, same latency.
  - Occupied slots show steady on. The assigned slot always blinks, even if marked occupied.
- Not defined: occupied port absent; led carries only the blink vector.

## Structure
- Shared package parking_pkg:
  - FSM state enum (IDLE, ON, OFF);
  - slot-to-one-hot function;
  - constant SLOT_NONE = 0.
- Sub-module led_phase_timer:
  - Loadable down-counter, width $clog2(max(ON_CYCLES,OFF_CYCLES)+1).
  - Ports: load, load value, expire pulse.
  - Instantiated once and reloaded on each phase change.

## Test plan
All with N_SLOTS=6, ON=4, OFF=4, BLINKS=2 unless stated.
- Basic run: start, slot=3 at edge 0 -> led=6'b000100 in cycles 1-4 and 9-12, 0 in 5-8 and 13-16; busy 1-16; done only in cycle 17.
- Invalid start: slot=0 and slot=7 -> err pulse in the next cycle; led=0, busy=0 unchanged. Also inject during an active run and check the run is unaffected.
- Retrigger: slot=2 start, then at cycle 6 start slot=5 -> led=6'b010000 from cycle 7 for a full 2-blink run; done once, at cycle 23.
- Cancel vs start: cancel and start on the same edge mid-run -> IDLE, led=0, no done. Also rst_n low at cycle 3 -> all outputs 0 from cycle 4.
- Continuous: BLINKS=0, slot=1 -> 6'b000001 keeps toggling 4/4 for 100 cycles with no done; cancel stops it.
- LED_OCCUPANCY_EN: occupied=6'b100110, start slot=2 -> led alternates 6'b100110 (ON) and 6'b100100 (OFF).
